// File: rtl/xor_stream_cipher.sv
// rtl/xor_stream_cipher.sv - XOR stream-cipher datapath with loadable key and keystream modes
//
// Purpose: XOR each accepted word with a keystream. The keystream is either fixed, rotated
// left, or stepped as a Galois LFSR after every accepted word. The output is a single-entry
// register stage with valid/ready handshaking. Reloading the same key and mode decrypts.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   key_load/key_in/mode  key and mode load pulse; accepted only while the output is empty
//   in_valid/in_ready     input handshake; data_in is the plaintext or ciphertext word
//   out_valid/out_ready   output handshake; res_out = data_in ^ keystream
//   zero_flag/parity_out  flags of the current res_out
//   word_count            saturating count of accepted words since reset or last key load
//   key_err               one-cycle pulse: key load ignored (output full) or zero LFSR seed replaced
module xor_stream_cipher #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] DEFAULT_KEY = 8'hAA,
  parameter logic [DATA_W-1:0] LFSR_TAPS   = 8'hB8,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_in,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res_out,
  output logic              zero_flag,
  output logic              parity_out,
  output logic [CNT_W-1:0]  word_count,
  output logic              key_err
);

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [DATA_W-1:0]  ks_q, ks_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               zero_q, zero_d;
  logic               parity_q, parity_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               key_err_q, key_err_d;

  logic               accept;
  logic               load_ok;

  assign out_valid  = (state_q == S_FULL);
  // A pending key load blocks input so data never sees a half-updated keystream.
  assign in_ready   = (!out_valid || out_ready) && !key_load;
  assign accept     = in_valid && in_ready;
  assign load_ok    = key_load && (state_q == S_EMPTY);

  assign res_out    = res_q;
  assign zero_flag  = zero_q;
  assign parity_out = parity_q;
  assign word_count = cnt_q;
  assign key_err    = key_err_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ks_d      = ks_q;
    res_d     = res_q;
    zero_d    = zero_q;
    parity_d  = parity_q;
    cnt_d     = cnt_q;
    key_err_d = 1'b0;

    if (load_ok) begin
      // An all-zero LFSR seed would lock up; substitute the default key and flag it.
      if ((mode == MODE_LFSR) && (key_in == '0)) begin
        ks_d      = DEFAULT_KEY;
        key_err_d = 1'b1;
      end else begin
        ks_d = key_in;
      end
      mode_d = mode_e'(mode);
      cnt_d  = '0;
    end else if (key_load) begin
      key_err_d = 1'b1;
    end

    // accept and load_ok are mutually exclusive because key_load forces in_ready low.
    if (accept) begin
      res_d    = data_in ^ ks_q;
      zero_d   = (res_d == '0);
      parity_d = ^res_d;
      cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      state_d  = S_FULL;
      case (mode_q)
        MODE_ROTATE: ks_d = {ks_q[DATA_W-2:0], ks_q[DATA_W-1]};
        MODE_LFSR:   ks_d = (ks_q >> 1) ^ (ks_q[0] ? LFSR_TAPS : '0);
        default:     ks_d = ks_q;
      endcase
    end else if (out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_EMPTY;
      mode_q    <= MODE_FIXED;
      ks_q      <= DEFAULT_KEY;
      res_q     <= '0;
      zero_q    <= 1'b0;
      parity_q  <= 1'b0;
      cnt_q     <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      ks_q      <= ks_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      parity_q  <= parity_d;
      cnt_q     <= cnt_d;
      key_err_q <= key_err_d;
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb/tb_xor_stream_cipher.sv - scoreboard bench for xor_stream_cipher
module tb_xor_stream_cipher;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_load = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic [1:0] mode = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data_in = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] res_out;
  logic       zero_flag;
  logic       parity_out;
  logic [3:0] word_count;
  logic       key_err;

  int n_cmp = 0;
  int n_fail = 0;
  int bp_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0

  int sb[$];
  int mks = 8'hAA;
  int mmode = 0;
  int mcnt = 0;

  xor_stream_cipher #(
    .DATA_W(8), .DEFAULT_KEY(8'hAA), .LFSR_TAPS(8'hB8), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_load(key_load), .key_in(key_in), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .res_out(res_out),
    .zero_flag(zero_flag), .parity_out(parity_out), .word_count(word_count), .key_err(key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference keystream step written from the mode rules as plain arithmetic.
  task automatic model_accept(input int d, input bit lit, input int litv);
    sb.push_back(lit ? litv : ((d ^ mks) & 255));
    if (mmode == 1) mks = ((mks * 2) % 256) + (mks / 128);
    else if (mmode == 2) mks = (mks / 2) ^ ((mks % 2 == 1) ? 'hB8 : 0);
    mcnt = (mcnt < 15) ? mcnt + 1 : 15;
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom % 2) : 1'b0;
  end

  // Monitor: pops the scoreboard whenever an output word is handed over.
  initial forever begin
    int e;
    @(negedge clk);
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none", res_out);
      end else begin
        e = sb.pop_front();
        chk("res_out", res_out, e);
        chk("zero_flag", zero_flag, (e == 0) ? 1 : 0);
        chk("parity_out", parity_out, $countones(e[7:0]) % 2);
      end
    end
  end

  task automatic send(input int d, input bit lit, input int litv);
    bit acc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    data_in = d[7:0];
    for (int i = 0; i < 300; i++) begin
      #1;
      if (in_ready) begin acc = 1; break; end
      @(posedge clk); #1;
    end
    if (acc) model_accept(d, lit, litv);
    else chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    bp_mode = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  task automatic load_key(input int k, input int m, input bit hold, input int hd, input int hexp);
    bit zseed;
    zseed = (m == 2 && k == 0);
    drain();
    @(posedge clk); #1;
    key_load = 1'b1;
    key_in = k[7:0];
    mode = m[1:0];
    if (hold) begin in_valid = 1'b1; data_in = hd[7:0]; end
    #1;
    chk("in_ready_during_load", in_ready, 0);
    @(posedge clk); #1;
    key_load = 1'b0;
    chk("key_err_load", key_err, zseed ? 1 : 0);
    chk("wc_after_load", word_count, 0);
    mks = zseed ? 'hAA : k;
    mmode = m;
    mcnt = 0;
    if (hold) begin
      #1;
      chk("held_data_accepted", in_ready, 1);
      model_accept(hd, 1, hexp);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #23;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_parity", parity_out, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_key_err", key_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: default key
    bp_mode = 0;
    send('h55, 1, 'hFF);
    drain();
    chk("t1_word_count", word_count, 1);

    // 2: FIXED 3C, data arrives together with key_load and must wait
    load_key('h3C, 0, 1, 'h3C, 'h00);
    drain();

    // 3: ROTATE
    load_key('h81, 1, 0, 0, 0);
    send(0, 1, 'h81); send(0, 1, 'h03); send(0, 1, 'h06);

    // 4: LFSR encrypt then decrypt
    load_key('h01, 2, 0, 0, 0);
    send(0, 1, 'h01); send(0, 1, 'hB8);
    load_key('h01, 2, 0, 0, 0);
    send('h01, 1, 'h00); send('hB8, 1, 'h00);

    // 5: stall with pending input; ks must not advance during the stall
    load_key('h81, 1, 0, 0, 0);
    bp_mode = 2;
    send(0, 1, 'h81);
    @(posedge clk); #1;
    in_valid = 1'b1;
    data_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_res_out", res_out, 'h81);
    end
    bp_mode = 0;
    send(0, 1, 'h03);
    drain();
    chk("t5_word_count", word_count, 2);

    // 6: key load while FULL is rejected
    load_key('h3C, 0, 0, 0, 0);
    bp_mode = 2;
    send(0, 1, 'h3C);
    @(posedge clk); #1;
    key_load = 1'b1; key_in = 8'h11; mode = 2'd0;
    @(posedge clk); #1;
    key_load = 1'b0;
    chk("full_load_key_err", key_err, 1);
    chk("full_load_out_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("key_err_pulse_end", key_err, 0);
    bp_mode = 0;
    send(0, 1, 'h3C);

    // LFSR with zero seed falls back to the default key
    load_key(0, 2, 0, 0, 0);
    send('h12, 1, 'hB8);
    drain();

    // word_count saturation (4-bit counter)
    load_key('h5A, 3, 0, 0, 0);
    for (int i = 0; i < 18; i++) send($urandom % 256, 0, 0);
    drain();
    chk("wc_saturated", word_count, 15);

    // Randomized phase with random backpressure
    for (int r = 0; r < 8; r++) begin
      load_key(((r % 4) == 3) ? 0 : $urandom % 256, $urandom % 4, 0, 0, 0);
      bp_mode = 1;
      for (int i = 0; i < 10 + $urandom_range(0, 20); i++) send($urandom % 256, 0, 0);
      drain();
      chk("rand_word_count", word_count, mcnt);
    end

    // Mid-stream reset
    bp_mode = 2;
    send('h77, 0, 0);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_word_count", word_count, 0);
    chk("midrst_res_out", res_out, 0);
    sb.delete();
    mks = 'hAA; mmode = 0; mcnt = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bp_mode = 0;
    send('h55, 1, 'hFF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
